// File: rtl/tactile_pkg.sv
// Shared types and constants for the tactile-matrix scan sequencer.
package tactile_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CONVERT,
      WRITE,
      DONE
   } scan_state_t;

   localparam int ADC_WIDTH = 12;
   localparam logic [ADC_WIDTH-1:0] ADC_TIMEOUT_DATA = 12'hFFF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter with a terminal-count flag; used for analog settling and ADC timeout.
module scan_settle_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_write,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_write or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Tactile matrix scan sequencer: walks every (sw,rd) crossing, settles, converts, writes to storage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for scan_en, selects parked at (0,0)
//   SETTLE  | mux selects stable, waiting for the analog path to settle
//   CONVERT | adc_start issued on entry, waiting for adc_done or timeout
//   WRITE   | one-cycle storage write strobe, selects advance on exit
//   DONE    | one-cycle frame_done pulse, restart or go idle
module matrix_scan_ctrl
   import tactile_pkg::*;
#(
   parameter int SW_WIRE_CNT   = 16,
   parameter int RD_WIRE_CNT   = 16,
   parameter int SW_SETTLE_CYC = 256,
   parameter int RD_SETTLE_CYC = 32,
   parameter int ADC_TIMEOUT   = 1024
) (
   input  logic                           clk_write,
   input  logic                           rst_n,
   input  logic                           scan_en,
   output logic                           adc_start,
   input  logic                           adc_done,
   input  logic [ADC_WIDTH-1:0]           adc_data,
   output logic [$clog2(SW_WIRE_CNT):0]   sw_sel,
   output logic [$clog2(RD_WIRE_CNT):0]   rd_sel,
   output logic [$clog2(SW_WIRE_CNT):0]   sw_write_out,
   output logic [$clog2(RD_WIRE_CNT):0]   rd_write_out,
   output logic [ADC_WIDTH-1:0]           data_out,
   output logic                           data_valid_out,
   output logic                           frame_done,
   output logic                           busy,
   output logic                           adc_timeout
);

   localparam int SW_IW    = $clog2(SW_WIRE_CNT) + 1;
   localparam int RD_IW    = $clog2(RD_WIRE_CNT) + 1;
   localparam int SETTLE_W = $clog2(max_int(SW_SETTLE_CYC, RD_SETTLE_CYC) + 1);
   localparam int TMO_W    = $clog2(ADC_TIMEOUT + 1);

   localparam logic [SETTLE_W-1:0] SW_LOAD  = SETTLE_W'(SW_SETTLE_CYC - 1);
   localparam logic [SETTLE_W-1:0] RD_LOAD  = SETTLE_W'(RD_SETTLE_CYC - 1);
   localparam logic [TMO_W-1:0]    TMO_LOAD = TMO_W'(ADC_TIMEOUT - 1);
   localparam logic [SW_IW-1:0]    SW_LAST  = SW_IW'(SW_WIRE_CNT - 1);
   localparam logic [RD_IW-1:0]    RD_LAST  = RD_IW'(RD_WIRE_CNT - 1);

   scan_state_t          state_q, state_d;
   logic [SW_IW-1:0]     sw_sel_q, sw_sel_d;
   logic [RD_IW-1:0]     rd_sel_q, rd_sel_d;
   logic [ADC_WIDTH-1:0] sample_q, sample_d;
   logic                 adc_start_q, adc_start_d;
   logic                 timeout_flag_q, timeout_flag_d;

   logic                 settle_load, settle_dec, settle_zero;
   logic [SETTLE_W-1:0]  settle_val;
   logic                 tmo_load, tmo_dec, tmo_zero;

   scan_settle_timer #(.WIDTH(SETTLE_W)) u_settle_timer (
      .clk_write (clk_write),
      .rst_n     (rst_n),
      .load      (settle_load),
      .load_val  (settle_val),
      .dec       (settle_dec),
      .zero      (settle_zero)
   );

   scan_settle_timer #(.WIDTH(TMO_W)) u_adc_timer (
      .clk_write (clk_write),
      .rst_n     (rst_n),
      .load      (tmo_load),
      .load_val  (TMO_LOAD),
      .dec       (tmo_dec),
      .zero      (tmo_zero)
   );

   always_comb begin
      state_d        = state_q;
      sw_sel_d       = sw_sel_q;
      rd_sel_d       = rd_sel_q;
      sample_d       = sample_q;
      adc_start_d    = 1'b0;
      timeout_flag_d = timeout_flag_q;
      settle_load    = 1'b0;
      settle_val     = SW_LOAD;
      settle_dec     = 1'b0;
      tmo_load       = 1'b0;
      tmo_dec        = 1'b0;

      case (state_q)
         IDLE: begin
            sw_sel_d = '0;
            rd_sel_d = '0;
            if (scan_en) begin
               state_d     = SETTLE;
               settle_load = 1'b1;
            end
         end
         SETTLE: begin
            settle_dec = 1'b1;
            if (settle_zero) begin
               state_d     = CONVERT;
               adc_start_d = 1'b1;
               tmo_load    = 1'b1;
            end
         end
         CONVERT: begin
            tmo_dec = 1'b1;
            // A done coincident with the request belongs to a previous conversion.
            if (adc_done && !adc_start_q) begin
               sample_d = adc_data;
               state_d  = WRITE;
            end else if (tmo_zero) begin
               sample_d       = ADC_TIMEOUT_DATA;
               timeout_flag_d = 1'b1;
               state_d        = WRITE;
            end
         end
         WRITE: begin
            if (rd_sel_q != RD_LAST) begin
               rd_sel_d    = rd_sel_q + RD_IW'(1);
               settle_load = 1'b1;
               settle_val  = RD_LOAD;
               state_d     = SETTLE;
            end else if (sw_sel_q != SW_LAST) begin
               rd_sel_d    = '0;
               sw_sel_d    = sw_sel_q + SW_IW'(1);
               settle_load = 1'b1;
               state_d     = SETTLE;
            end else begin
               rd_sel_d = '0;
               sw_sel_d = '0;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (scan_en) begin
               state_d     = SETTLE;
               settle_load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_write or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         sw_sel_q       <= '0;
         rd_sel_q       <= '0;
         sample_q       <= '0;
         adc_start_q    <= 1'b0;
         timeout_flag_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         sw_sel_q       <= sw_sel_d;
         rd_sel_q       <= rd_sel_d;
         sample_q       <= sample_d;
         adc_start_q    <= adc_start_d;
         timeout_flag_q <= timeout_flag_d;
      end
   end

   assign adc_start      = adc_start_q;
   assign sw_sel         = sw_sel_q;
   assign rd_sel         = rd_sel_q;
   assign sw_write_out   = sw_sel_q;
   assign rd_write_out   = rd_sel_q;
   assign data_out       = sample_q;
   assign data_valid_out = (state_q == WRITE);
   assign frame_done     = (state_q == DONE);
   assign busy           = (state_q != IDLE);
   assign adc_timeout    = timeout_flag_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl on a 4x4 matrix with a behavioural ADC.
module tb_matrix_scan_ctrl;

   localparam int SW  = 4;
   localparam int RD  = 4;
   localparam int SWS = 4;
   localparam int RDS = 2;
   localparam int TO  = 16;
   localparam int LAT = 5;
   localparam int NPT = SW * RD;

   logic        clk_write = 1'b0;
   logic        rst_n;
   logic        scan_en;
   logic        adc_start;
   logic        adc_done;
   logic [11:0] adc_data;
   logic [2:0]  sw_sel, rd_sel, sw_write_out, rd_write_out;
   logic [11:0] data_out;
   logic        data_valid_out, frame_done, busy, adc_timeout;

   always #5 clk_write = ~clk_write;

   matrix_scan_ctrl #(
      .SW_WIRE_CNT   (SW),
      .RD_WIRE_CNT   (RD),
      .SW_SETTLE_CYC (SWS),
      .RD_SETTLE_CYC (RDS),
      .ADC_TIMEOUT   (TO)
   ) dut (
      .clk_write      (clk_write),
      .rst_n          (rst_n),
      .scan_en        (scan_en),
      .adc_start      (adc_start),
      .adc_done       (adc_done),
      .adc_data       (adc_data),
      .sw_sel         (sw_sel),
      .rd_sel         (rd_sel),
      .sw_write_out   (sw_write_out),
      .rd_write_out   (rd_write_out),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .frame_done     (frame_done),
      .busy           (busy),
      .adc_timeout    (adc_timeout)
   );

   typedef struct {
      int          sw;
      int          rd;
      logic [11:0] data;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t mdl_e;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int writes = 0;
   int frames = 0;
   int pt = 0;
   int no_resp_pt = -1;
   bit spur_start = 0;
   bit spur_settle = 0;

   int       last_start_cyc = 0;
   int       last_write_cyc = -10;
   int       last_pt = -1;
   logic [2:0] prev_sw = '0, prev_rd = '0;
   int       chg_cnt = 0;
   bit       chg_valid = 0;
   bit       chg_sw = 0;

   // ADC model: answers each request LAT cycles later, optionally with spurious dones.
   initial begin
      logic [11:0] d;
      adc_done = 1'b0;
      adc_data = '0;
      forever begin
         @(negedge clk_write);
         adc_done = 1'b0;
         if (rst_n && adc_start) begin
            checks++;
            if (sw_sel !== 3'(pt / RD) || rd_sel !== 3'(pt % RD)) begin
               failures++;
               $display("FAIL start_sel got=(%0d,%0d) expected=(%0d,%0d)", sw_sel, rd_sel, pt / RD, pt % RD);
            end
            mdl_e.sw = pt / RD;
            mdl_e.rd = pt % RD;
            if (pt == no_resp_pt) begin
               mdl_e.data = 12'hFFF;
               mdl_e.lat  = TO;
               exp_q.push_back(mdl_e);
               pt = (pt + 1) % NPT;
            end else begin
               d = 12'($urandom);
               mdl_e.data = d;
               mdl_e.lat  = LAT + 1;
               exp_q.push_back(mdl_e);
               pt = (pt + 1) % NPT;
               if (spur_start) begin
                  adc_done = 1'b1;
                  adc_data = ~d;
               end
               repeat (LAT) begin
                  @(negedge clk_write);
                  adc_done = 1'b0;
               end
               adc_done = 1'b1;
               adc_data = d;
               if (spur_settle) begin
                  @(negedge clk_write);
                  adc_done = 1'b0;
                  @(negedge clk_write);
                  adc_done = 1'b1;
                  adc_data = ~d;
               end
            end
         end
      end
   end

   // Output monitor: scoreboard pop on writes, settle timing and frame_done placement.
   initial begin
      forever begin
         @(negedge clk_write);
         cyc++;
         if (!rst_n) begin
            chg_valid = 0;
            prev_sw   = '0;
            prev_rd   = '0;
         end else begin
            if (sw_sel !== prev_sw || rd_sel !== prev_rd) begin
               chg_cnt   = 0;
               chg_valid = !(sw_sel == 3'd0 && rd_sel == 3'd0);
               chg_sw    = (sw_sel !== prev_sw);
            end else begin
               chg_cnt++;
            end
            prev_sw = sw_sel;
            prev_rd = rd_sel;
            if (adc_start) begin
               last_start_cyc = cyc;
               if (chg_valid) begin
                  checks++;
                  if (chg_cnt != (chg_sw ? SWS : RDS)) begin
                     failures++;
                     $display("FAIL settle_time sw_change=%0d got=%0d expected=%0d", chg_sw, chg_cnt, chg_sw ? SWS : RDS);
                  end
                  chg_valid = 0;
               end
            end
            if (data_valid_out) begin
               writes++;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_write got=(%0d,%0d,%h) expected no write", sw_write_out, rd_write_out, data_out);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (sw_write_out !== 3'(mon_e.sw) || rd_write_out !== 3'(mon_e.rd)) begin
                     failures++;
                     $display("FAIL write_index got=(%0d,%0d) expected=(%0d,%0d)", sw_write_out, rd_write_out, mon_e.sw, mon_e.rd);
                  end
                  checks++;
                  if (data_out !== mon_e.data) begin
                     failures++;
                     $display("FAIL write_data at (%0d,%0d) got=%h expected=%h", mon_e.sw, mon_e.rd, data_out, mon_e.data);
                  end
                  checks++;
                  if (cyc - last_start_cyc != mon_e.lat) begin
                     failures++;
                     $display("FAIL write_latency at (%0d,%0d) got=%0d expected=%0d", mon_e.sw, mon_e.rd, cyc - last_start_cyc, mon_e.lat);
                  end
                  last_write_cyc = cyc;
                  last_pt = mon_e.sw * RD + mon_e.rd;
               end
            end
            if (frame_done) begin
               frames++;
               checks++;
               if (last_write_cyc != cyc - 1 || last_pt != NPT - 1) begin
                  failures++;
                  $display("FAIL frame_done_place got last_pt=%0d gap=%0d expected last_pt=%0d gap=1", last_pt, cyc - last_write_cyc, NPT - 1);
               end
            end
         end
      end
   end

   task automatic wait_frame_done(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_write);
         if (frame_done) break;
      end
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("FAIL %s frame_done_wait got=no pulse expected=pulse within %0d cycles", name, budget);
      end
   endtask

   task automatic pulse_scan_en();
      @(negedge clk_write);
      scan_en = 1'b1;
      @(negedge clk_write);
      scan_en = 1'b0;
   endtask

   task automatic check_idle_frame(input string name, input int w0, input int f0, input int nw, input int nf);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s busy_after got=%b expected=0", name, busy);
      end
      checks++;
      if (writes - w0 != nw) begin
         failures++;
         $display("FAIL %s write_count got=%0d expected=%0d", name, writes - w0, nw);
      end
      checks++;
      if (frames - f0 != nf) begin
         failures++;
         $display("FAIL %s frame_count got=%0d expected=%0d", name, frames - f0, nf);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s pending_points got=%0d expected=0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      scan_en = 1'b0;
      repeat (3) @(negedge clk_write);
      checks++;
      if ({adc_start, data_valid_out, frame_done, busy, adc_timeout} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b expected=00000", {adc_start, data_valid_out, frame_done, busy, adc_timeout});
      end
      checks++;
      if ({sw_sel, rd_sel, sw_write_out, rd_write_out, data_out} !== '0) begin
         failures++;
         $display("FAIL reset_sel got=%0d,%0d,%0d,%0d,%h expected=all zero", sw_sel, rd_sel, sw_write_out, rd_write_out, data_out);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk_write);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_no_en got busy=%b expected=0", busy);
      end
   endtask

   task automatic test_single_frame();
      int w0 = writes;
      int f0 = frames;
      pulse_scan_en();
      wait_frame_done("single", 1000);
      repeat (3) @(negedge clk_write);
      check_idle_frame("single", w0, f0, NPT, 1);
   endtask

   task automatic test_back_to_back();
      int w0 = writes;
      int f0 = frames;
      @(negedge clk_write);
      scan_en = 1'b1;
      wait_frame_done("b2b_first", 1000);
      @(negedge clk_write);
      checks++;
      if (busy !== 1'b1 || sw_sel !== 3'd0 || rd_sel !== 3'd0) begin
         failures++;
         $display("FAIL b2b_restart got busy=%b sel=(%0d,%0d) expected busy=1 sel=(0,0)", busy, sw_sel, rd_sel);
      end
      wait_frame_done("b2b_second", 1000);
      scan_en = 1'b0;
      repeat (3) @(negedge clk_write);
      check_idle_frame("b2b", w0, f0, 2 * NPT, 2);
   endtask

   task automatic test_timeout();
      int w0 = writes;
      int f0 = frames;
      checks++;
      if (adc_timeout !== 1'b0) begin
         failures++;
         $display("FAIL timeout_before got=%b expected=0", adc_timeout);
      end
      no_resp_pt = 1 * RD + 2;
      pulse_scan_en();
      wait_frame_done("timeout", 2000);
      no_resp_pt = -1;
      repeat (3) @(negedge clk_write);
      checks++;
      if (adc_timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_sticky got=%b expected=1", adc_timeout);
      end
      check_idle_frame("timeout", w0, f0, NPT, 1);
   endtask

   task automatic test_spurious();
      int w0 = writes;
      int f0 = frames;
      spur_start  = 1;
      spur_settle = 1;
      pulse_scan_en();
      wait_frame_done("spurious", 1000);
      spur_start  = 0;
      spur_settle = 0;
      repeat (3) @(negedge clk_write);
      check_idle_frame("spurious", w0, f0, NPT, 1);
      checks++;
      if (adc_timeout !== 1'b1) begin
         failures++;
         $display("FAIL spurious_timeout_kept got=%b expected=1", adc_timeout);
      end
   endtask

   task automatic test_reset_mid();
      int  w0;
      int  f0 = frames;
      bit  found = 0;
      pulse_scan_en();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_write);
         if (adc_start && sw_sel == 3'd2 && rd_sel == 3'd1) begin
            found = 1;
            break;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL rst_mid_reach got=not reached expected=CONVERT at (2,1)");
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({adc_start, data_valid_out, frame_done, busy, adc_timeout} !== 5'b0) begin
         failures++;
         $display("FAIL rst_mid_flags got=%b expected=00000", {adc_start, data_valid_out, frame_done, busy, adc_timeout});
      end
      checks++;
      if (sw_sel !== 3'd0 || rd_sel !== 3'd0) begin
         failures++;
         $display("FAIL rst_mid_sel got=(%0d,%0d) expected=(0,0)", sw_sel, rd_sel);
      end
      repeat (12) @(negedge clk_write);
      exp_q.delete();
      pt = 0;
      @(negedge clk_write);
      rst_n = 1'b1;
      w0 = writes;
      pulse_scan_en();
      wait_frame_done("rst_mid", 1000);
      repeat (3) @(negedge clk_write);
      check_idle_frame("rst_mid", w0, f0, NPT, 1);
   endtask

   initial begin
      rst_n   = 1'b0;
      scan_en = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_timeout();
      test_spurious();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
